// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory write controller: state enum,
// default sizes and the address-width helper.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 20;
  localparam int unsigned DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  // Address bits needed to index DEPTH words (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 32'd1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_write_ctrl_if.sv
// Sample stream and memory write pins of the write controller.
// master = controller side, slave = upstream source / memory side.
interface mem_write_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = addr_width(DEPTH_DEF)
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_din, mem_we
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/mem_write_ctrl.sv
// Fills DEPTH memory words from a valid/ready sample stream at sequential addresses.
// Define MEM_WRITE_CTRL_WRAP_EN for ring mode (keep filling and overwrite oldest words).
module mem_write_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  mem_write_ctrl_if.master  bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                in_ready_c;
  logic                accept_c;

  // Never accept in a start or abort cycle so a restart cannot lose or duplicate a write.
  always_comb begin
    in_ready_c = (state_q == FILL) && !start && !abort;
    accept_c   = bus.in_valid && in_ready_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    full_d  = full_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;

    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = FILL;
      ptr_d   = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (accept_c) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      din_d  = bus.in_data;
      ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
      // The DEPTH-th write; done only marks the first time full rises.
      if (count_q == CNT_LAST) begin
        full_d = 1'b1;
        done_d = !full_q;
`ifdef MEM_WRITE_CTRL_WRAP_EN
        state_d = FILL;
`else
        state_d = FULL;
`endif
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign count        = count_q;
  assign full         = full_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Self-checking bench for mem_write_ctrl: directed vector table, corner sequences
// and randomized traffic against a behavioural fill model.
module tb_mem_write_ctrl;
  import mem_ctrl_pkg::*;

  localparam int DW    = 20;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic [AW:0] count;
  logic full;
  logic done;

  mem_write_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_write_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .bus   (bus.master),
    .count (count),
    .full  (full),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_seen;

  // Behavioural model: is the block taking samples, where the next word goes,
  // how many words are written, and what the memory pins should show.
  bit        m_active;
  int        m_wp;
  int        m_cnt;
  bit        m_full;
  bit        e_we;
  int        e_addr;
  logic [DW-1:0] e_din;
  bit        e_done;

  typedef struct {
    logic          s, a, v;
    logic [DW-1:0] d;
    logic          rdy, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [AW:0]   cnt;
    logic          full, done;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wp = 0; m_cnt = 0; m_full = 0;
    e_we = 0; e_addr = 0; e_din = '0; e_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    #2;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_we",    bus.mem_we, 0);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_din",   bus.mem_din, 0);
    chk("rst_count", count, 0);
    chk("rst_full",  full, 0);
    chk("rst_done",  done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, check ready mid-cycle, clock, check registered outputs.
  task automatic step(input logic s, input logic a, input logic v, input logic [DW-1:0] d);
    bit m_ready;
    start = s; abort = a; bus.in_valid = v; bus.in_data = d;
    m_ready = m_active && !s && !a;
    #3;
    chk("in_ready", bus.in_ready, m_ready);
    @(posedge clk); #1;
    e_we = 0; e_done = 0;
    if (a) begin
      m_active = 0;
    end else if (s) begin
      m_active = 1; m_wp = 0; m_cnt = 0; m_full = 0;
    end else if (m_ready && v) begin
      e_we = 1; e_addr = m_wp; e_din = d;
      m_wp = (m_wp + 1) % DEPTH;
      if (m_cnt < DEPTH) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          e_done = !m_full;
          m_full = 1;
`ifndef MEM_WRITE_CTRL_WRAP_EN
          m_active = 0;
`endif
        end
      end
    end
    if (done === 1'b1) done_seen++;
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_din", bus.mem_din, e_din);
    chk("count", count, m_cnt);
    chk("full", full, m_full);
    chk("done", done, e_done);
  endtask

  task automatic apply_vec(input int i);
    start = vecs[i].s; abort = vecs[i].a; bus.in_valid = vecs[i].v; bus.in_data = vecs[i].d;
    #3;
    chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].rdy);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_we", i),   bus.mem_we, vecs[i].we);
    chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].addr);
    chk($sformatf("vec%0d_din", i),  bus.mem_din, vecs[i].din);
    chk($sformatf("vec%0d_cnt", i),  count, vecs[i].cnt);
    chk($sformatf("vec%0d_full", i), full, vecs[i].full);
    chk($sformatf("vec%0d_done", i), done, vecs[i].done);
  endtask

  initial begin
    logic [AW-1:0] tail_addr [4];
    int budget;

    // start/abort/valid/data -> ready, we, addr, din, count, full, done
    vecs[0] = '{1'b1, 1'b0, 1'b1, 20'h11111, 1'b0, 1'b0, 8'd0, 20'h00000, 9'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 20'hA5A5A, 1'b1, 1'b1, 8'd0, 20'hA5A5A, 9'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 20'hFFFFF, 1'b1, 1'b0, 8'd0, 20'hA5A5A, 9'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 20'h12345, 1'b1, 1'b1, 8'd1, 20'h12345, 9'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 8'd1, 20'h12345, 9'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 20'h00777, 1'b1, 1'b1, 8'd0, 20'h00777, 9'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 20'h0BEEF, 1'b0, 1'b0, 8'd0, 20'h00777, 9'd1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 20'h0CAFE, 1'b0, 1'b0, 8'd0, 20'h00777, 9'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 20'h0F00D, 1'b0, 1'b0, 8'd0, 20'h00777, 9'd1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 20'h0D00D, 1'b0, 1'b0, 8'd0, 20'h00777, 9'd1, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) apply_vec(i);

    // Abort at count 10, then restart from address 0.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, 1'b1, 1'b1, DW'($urandom));
    chk("abort_count", count, 10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b1, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, 1'b0, 1'b1, 20'h54321);
    chk("restart_addr", bus.mem_addr, 0);
    chk("restart_count", count, 1);

    // Complete fill with random valid gaps.
    do_reset();
    done_seen = 0;
    step(1'b1, 1'b0, 1'b0, '0);
    budget = 3000;
    while (m_cnt < DEPTH && budget > 0) begin
      step(1'b0, 1'b0, ($urandom % 4) != 0, DW'($urandom));
      budget--;
    end
    chk("fill_count", count, DEPTH);
    chk("fill_full", full, 1);
`ifdef MEM_WRITE_CTRL_WRAP_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, DW'($urandom));
      tail_addr[i] = bus.mem_addr;
    end
    for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(tail_addr[i]), i);
    chk("wrap_count", count, DEPTH);
    chk("wrap_full", full, 1);
`else
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    chk("full_count_hold", count, DEPTH);
    chk("full_we_idle", bus.mem_we, 0);
`endif
    chk("done_pulses", done_seen, 1);

    // Asynchronous reset in the middle of a fill.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    chk("pre_rst_we", bus.mem_we, 1);
    do_reset();

    // Randomized traffic with occasional start/abort.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 60) == 0, ($urandom % 90) == 0, ($urandom % 10) < 7, DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
